// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding and opcode field layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrop,
    StHalt
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear beats load, otherwise contents hold.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      // The PC field is left as-is; only the live bit and the word matter downstream.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake FSM and IF/ID register.
// Optional perf counters enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic        pc_load,
  input  logic        stall,
  output logic [15:0] pc_curr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  hold_instr_q, hold_pc_q;
  logic         hold_we;
  logic         halted_q;
  logic         ifid_load, ifid_clear;
  logic [15:0]  ifid_in_instr, ifid_in_pc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_we       = 1'b0;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    ifid_in_instr = imem_rdata;
    ifid_in_pc    = pc_q;

    if (pc_load) begin
      // Redirect wins over everything, including stall and same-cycle data.
      pc_d       = next_pc;
      ifid_clear = 1'b1;
      unique case (state_q)
        StFetch: state_d = imem_valid ? StFetch : StDrop;
        StDrop:  state_d = imem_valid ? StFetch : StDrop;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_valid) begin
            if (stall) begin
              hold_we = 1'b1;
              state_d = StHold;
            end else begin
              ifid_load = 1'b1;
              if (opcode_of(imem_rdata) == HALT_OPCODE) state_d = StHalt;
              else                                      pc_d    = next_pc;
            end
          end else if (!stall) begin
            ifid_clear = 1'b1;
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_in_instr = hold_instr_q;
            ifid_in_pc    = hold_pc_q;
            if (opcode_of(hold_instr_q) == HALT_OPCODE) begin
              state_d = StHalt;
            end else begin
              pc_d    = next_pc;
              state_d = StFetch;
            end
          end
        end
        StDrop: begin
          if (imem_valid) state_d = StFetch;
          if (!stall)     ifid_clear = 1'b1;
        end
        StHalt: begin
          if (!stall) ifid_clear = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 16'h0000;
      halted_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == StHalt);
      if (hold_we) begin
        hold_instr_q <= imem_rdata;
        hold_pc_q    <= pc_q;
      end
    end
  end

  // Gated by rst_n so no request is visible while reset is held.
  assign imem_req  = rst_n && (state_q == StFetch);
  assign imem_addr = pc_q;
  assign pc_curr   = pc_q;
  assign halted    = halted_q;

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .instr_i (ifid_in_instr),
    .pc_i    (ifid_in_pc),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc),
    .valid_o (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (stall && ifid_valid && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (pc_load && (flush_cnt_q != 16'hFFFF))             flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 16'h0000;
  assign perf_flush_cnt = 16'h0000;
`endif

endmodule
